// File: rtl/if_prefetch.sv
// if_prefetch -- instruction-fetch stage with a prefetch queue.
//
// Owns the fetch PC and issues in-order word requests to instruction memory
// with a req/gnt handshake. Returned words are tagged with the PC they were
// fetched from and buffered in a DEPTH-entry FIFO that feeds decode through
// a valid/ready handshake. A redirect from execute reloads the PC, empties the
// FIFO and marks every still-outstanding response for discard.
//
// Ports
//   i_clk, i_rstn               clock, synchronous active-low reset
//   i_redirect, i_redirect_pc   take a new PC this cycle (bits [1:0] ignored)
//   o_mem_req, o_mem_addr       fetch request and its word address
//   i_mem_gnt                   memory accepts the request this cycle
//   i_mem_rvalid, i_mem_rdata   in-order response from memory
//   o_valid, o_inst, o_pc,      FIFO head towards decode
//   o_pc_plus4
//   i_ready                     decode consumes the head
module if_prefetch #(
   parameter int                 XLEN     = 32,
   parameter logic [XLEN-1:0]    RESET_PC = '0,
   parameter int                 DEPTH    = 4
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_mem_req,
   output logic [XLEN-1:0] o_mem_addr,
   input  logic            i_mem_gnt,
   input  logic            i_mem_rvalid,
   input  logic [31:0]     i_mem_rdata,
   output logic            o_valid,
   output logic [31:0]     o_inst,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus4,
   input  logic            i_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // Control state
   logic [XLEN-1:0] pc;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [AW-1:0]   tag_rd, tag_wr;
   logic [CW-1:0]   count, outstanding, discard;

   // Data storage (not reset; qualified by count / outstanding)
   logic [XLEN-1:0] fifo_pc   [DEPTH];
   logic [31:0]     fifo_inst [DEPTH];
   logic [XLEN-1:0] tag_pc    [DEPTH];

   logic credit, issue, push, pop;
   logic unused_lsbs;

   // Redirect targets are word aligned; the low bits are simply dropped.
   assign unused_lsbs = ^i_redirect_pc[1:0];

   // Entries already buffered plus responses still owed may never exceed
   // DEPTH, so every response is guaranteed a FIFO slot on arrival.
   assign credit = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

   assign o_mem_req  = i_rstn && !i_redirect && credit;
   assign o_mem_addr = pc;
   assign issue      = o_mem_req && i_mem_gnt;

   // A response is dropped while stale ones are pending or when it lands in
   // the redirect cycle itself.
   assign push = i_rstn && i_mem_rvalid && !i_redirect && (discard == '0);
   assign pop  = o_valid && i_ready && !i_redirect;

   assign o_valid    = (count != '0);
   assign o_inst     = o_valid ? fifo_inst[rd_ptr] : '0;
   assign o_pc       = o_valid ? fifo_pc[rd_ptr] : '0;
   assign o_pc_plus4 = o_valid ? fifo_pc[rd_ptr] + XLEN'(4) : '0;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         pc          <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (i_redirect) begin
         pc          <= {i_redirect_pc[XLEN-1:2], 2'b00};
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         // Everything still in flight belongs to the old stream; a response
         // arriving now is consumed here and not counted again.
         outstanding <= outstanding - CW'(i_mem_rvalid);
         discard     <= outstanding - CW'(i_mem_rvalid);
         tag_rd      <= tag_rd + AW'(i_mem_rvalid);
      end else begin
         if (issue) begin
            pc     <= pc + XLEN'(4);
            tag_wr <= tag_wr + AW'(1);
         end
         if (i_mem_rvalid) begin
            tag_rd <= tag_rd + AW'(1);
            if (discard != '0) begin
               discard <= discard - CW'(1);
            end
         end
         outstanding <= outstanding + CW'(issue) - CW'(i_mem_rvalid);
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Issued PCs are queued in request order so each response can be tagged.
   always_ff @(posedge i_clk) begin
      if (issue) begin
         tag_pc[tag_wr] <= pc;
      end
      if (push) begin
         fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
         fifo_inst[wr_ptr] <= i_mem_rdata;
      end
   end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch -- randomized self-checking bench for if_prefetch.
//
// A behavioural memory hands out in-order responses after a configurable
// latency. The reference model tracks the fetch PC, an epoch number bumped on
// every redirect/reset, and the expected FIFO contents as a queue; responses
// from an older epoch are expected to vanish.
module tb_if_prefetch;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rstn;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        ready;

   if_prefetch #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .o_mem_req    (mem_req),
      .o_mem_addr   (mem_addr),
      .i_mem_gnt    (mem_gnt),
      .i_mem_rvalid (mem_rvalid),
      .i_mem_rdata  (mem_rdata),
      .o_valid      (valid),
      .o_inst       (inst),
      .o_pc         (pc),
      .o_pc_plus4   (pc_plus4),
      .i_ready      (ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int ep; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   req_t        mq[$];   // requests granted, response not yet returned
   ent_t        fq[$];   // expected FIFO contents, head first
   logic [31:0] m_pc;
   int          ep       = 0;
   int          cyc      = 0;
   int          last_due = 0;
   int          lat      = 1;
   int          n_cmp    = 0;
   int          n_err    = 0;

   function automatic logic [31:0] finst(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, check, advance the model, wait edge.
   task automatic step(input logic rst_n, input logic redir, input logic [31:0] tgt,
                       input logic rdy, input logic gnt);
      logic rv;
      logic ereq;
      req_t r;
      ent_t e;
      int   due;
      @(negedge clk);
      rv = rst_n && (mq.size() > 0) && (mq[0].due <= cyc);
      rstn        = rst_n;
      redirect    = redir;
      redirect_pc = tgt;
      ready       = rdy;
      mem_gnt     = gnt;
      mem_rvalid  = rv;
      mem_rdata   = rv ? finst(mq[0].addr) : $urandom;
      #1;
      ereq = rst_n && !redir && ((fq.size() + mq.size()) < DEPTH);
      chk("mem_req", {31'd0, mem_req}, {31'd0, ereq});
      chk("mem_addr", mem_addr, m_pc);
      chk("valid", {31'd0, valid}, {31'd0, fq.size() != 0});
      if (fq.size() != 0) begin
         chk("head_pc", pc, fq[0].pc);
         chk("head_inst", inst, fq[0].inst);
         chk("head_pc4", pc_plus4, fq[0].pc + 32'd4);
      end else if (!rst_n) begin
         chk("rst_inst", inst, 32'd0);
         chk("rst_pc", pc, 32'd0);
         chk("rst_pc4", pc_plus4, 32'd0);
      end
      if (!rst_n) begin
         m_pc = RPC;
         fq.delete();
         ep++;
      end else begin
         if (rv) r = mq.pop_front();
         if (redir) begin
            fq.delete();
            ep++;
            m_pc = {tgt[31:2], 2'b00};
         end else begin
            if (fq.size() != 0 && rdy) void'(fq.pop_front());
            if (rv && r.ep == ep) begin
               e.pc   = r.addr;
               e.inst = finst(r.addr);
               fq.push_back(e);
            end
            if (ereq && gnt) begin
               due = cyc + lat;
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               r.addr = m_pc;
               r.ep   = ep;
               r.due  = due;
               mq.push_back(r);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic quiesce();
      int n;
      n = 0;
      while (mq.size() != 0 && n < 50) begin
         step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
         n++;
      end
      chk("quiesce", mq.size(), 0);
   endtask

   initial begin
      logic [31:0] tgt;
      int          rp, gp, n;
      rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      m_pc = RPC;
      @(posedge clk);
      cyc++;
      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

      // Streaming from reset with single-cycle memory
      lat = 1;
      repeat (20) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      // Backpressure, then drain
      repeat (12) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      chk("bp_full", fq.size(), DEPTH);
      repeat (12) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      // Redirect with three responses in flight
      lat = 3;
      n = 0;
      while (mq.size() != 3 && n < 20) begin
         step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
         n++;
      end
      chk("inflight3", mq.size(), 3);
      step(1'b1, 1'b1, 32'h0000_2003, 1'b1, 1'b1);
      repeat (15) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      // Redirect coinciding with a response and a pop, to the top of memory
      lat = 1;
      repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
      repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      // Grant stall
      repeat (5) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      // Randomized traffic
      rp = 70; gp = 70;
      for (int i = 0; i < 2000; i++) begin
         if (i % 100 == 0) begin
            quiesce();
            lat = $urandom_range(4, 1);
            rp  = $urandom_range(100, 20);
            gp  = $urandom_range(100, 20);
         end
         case ($urandom_range(3))
            0:       tgt = 32'hFFFF_FFF8 | ($urandom & 32'h7);
            default: tgt = $urandom;
         endcase
         step(1'b1, ($urandom_range(99) < 4), tgt,
              ($urandom_range(99) < rp), ($urandom_range(99) < gp));
      end

      // Mid-operation reset with entries buffered
      lat = 1;
      repeat (6) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      quiesce();
      repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
